// File: rtl/sm3_adder_arb_pkg.sv
// Shared SM3 definitions: word width, default requester count, 3-input add helper.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package sm3_adder_arb_pkg;

   localparam int SM3_WORD_W  = 32;
   localparam int SM3_NUM_REQ = 4;

   typedef logic [SM3_WORD_W-1:0] sm3_word_t;

   // Carry out of bit 31 is dropped on purpose; SM3 arithmetic is mod 2^32.
   function automatic sm3_word_t sm3_add3(input sm3_word_t a, input sm3_word_t b,
                                          input sm3_word_t c);
      return a + b + c;
   endfunction

endpackage

// File: rtl/sm3_adder.sv
// Purpose: combinational 3-input modulo-2^32 adder shared by the arbiter.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the caller registers the result.
module sm3_adder
   import sm3_adder_arb_pkg::*;
(
   input  logic [SM3_WORD_W-1:0] a,
   input  logic [SM3_WORD_W-1:0] b,
   input  logic [SM3_WORD_W-1:0] c,
   output logic [SM3_WORD_W-1:0] sum
);

   assign sum = sm3_add3(a, b, c);

endmodule

// File: rtl/sm3_adder_arb.sv
// Purpose: round-robin arbiter sharing one 3-input adder among NUM_REQ requesters.
// Latency: 1 cycle from request handshake to registered rsp_sum / rsp_id.
// Backpressure: a stalled response (rsp_valid && !rsp_ready) blocks every new grant.
module sm3_adder_arb
   import sm3_adder_arb_pkg::*;
#(
   parameter int NUM_REQ = SM3_NUM_REQ,
   // NUM_REQ must not exceed 2**ID_W so every requester index fits in rsp_id.
   parameter int ID_W    = 2
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_REQ-1:0]            req_valid,
   output logic [NUM_REQ-1:0]            req_ready,
   input  logic [NUM_REQ*SM3_WORD_W-1:0] req_a,
   input  logic [NUM_REQ*SM3_WORD_W-1:0] req_b,
   input  logic [NUM_REQ*SM3_WORD_W-1:0] req_c,
   output logic                          rsp_valid,
   input  logic                          rsp_ready,
   output logic [ID_W-1:0]               rsp_id,
   output logic [SM3_WORD_W-1:0]         rsp_sum
);

   logic                  rsp_valid_q, rsp_valid_d;
   logic [ID_W-1:0]       rsp_id_q,    rsp_id_d;
   logic [SM3_WORD_W-1:0] rsp_sum_q,   rsp_sum_d;
   logic [ID_W-1:0]       ptr_q,       ptr_d;

   logic                  can_accept;
   logic                  gnt_vld;
   logic [ID_W-1:0]       gnt_idx;
   logic                  handshake;
   logic [SM3_WORD_W-1:0] op_a, op_b, op_c;
   logic [SM3_WORD_W-1:0] add_sum;

   // The output slot can take a new result if it is empty or being drained now.
   assign can_accept = !rsp_valid_q || rsp_ready;
   // Reset gates the handshake so nothing is accepted while rst is high.
   assign handshake  = gnt_vld && can_accept && !rst;

   // Round-robin pick: first set req_valid bit scanning from ptr+1, wrapping.
   always_comb begin
      int scan_idx;
      scan_idx = 0;
      gnt_vld  = 1'b0;
      gnt_idx  = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         scan_idx = (int'(ptr_q) + k) % NUM_REQ;
         if (!gnt_vld && req_valid[scan_idx]) begin
            gnt_vld = 1'b1;
            gnt_idx = ID_W'(scan_idx);
         end
      end
   end

   // One-hot accept to the granted requester, only when the handshake can happen.
   always_comb begin
      req_ready = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         req_ready[i] = handshake && (int'(gnt_idx) == i);
      end
   end

   // Operand mux feeding the shared adder from the granted requester's lanes.
   always_comb begin
      op_a = '0;
      op_b = '0;
      op_c = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (int'(gnt_idx) == i) begin
            op_a = req_a[i*SM3_WORD_W +: SM3_WORD_W];
            op_b = req_b[i*SM3_WORD_W +: SM3_WORD_W];
            op_c = req_c[i*SM3_WORD_W +: SM3_WORD_W];
         end
      end
   end

   sm3_adder u_adder (
      .a   (op_a),
      .b   (op_b),
      .c   (op_c),
      .sum (add_sum)
   );

   // Response slot and pointer update: load on handshake, clear on pure drain.
   always_comb begin
      rsp_valid_d = rsp_valid_q;
      rsp_id_d    = rsp_id_q;
      rsp_sum_d   = rsp_sum_q;
      ptr_d       = ptr_q;
      if (handshake) begin
         rsp_valid_d = 1'b1;
         rsp_id_d    = gnt_idx;
         rsp_sum_d   = add_sum;
         ptr_d       = gnt_idx;
      end else if (rsp_ready) begin
         rsp_valid_d = 1'b0;
      end
   end

   // State registers; reset leaves ptr on the last index so requester 0 wins first.
   always_ff @(posedge clk) begin
      if (rst) begin
         rsp_valid_q <= 1'b0;
         rsp_id_q    <= '0;
         rsp_sum_q   <= '0;
         ptr_q       <= ID_W'(NUM_REQ - 1);
      end else begin
         rsp_valid_q <= rsp_valid_d;
         rsp_id_q    <= rsp_id_d;
         rsp_sum_q   <= rsp_sum_d;
         ptr_q       <= ptr_d;
      end
   end

   assign rsp_valid = rsp_valid_q;
   assign rsp_id    = rsp_id_q;
   assign rsp_sum   = rsp_sum_q;

endmodule

// File: tb/tb_sm3_adder_arb.sv
// Bench for sm3_adder_arb: directed vectors plus held-valid random traffic.
// Responses are checked by a monitor popping an expected-response queue.
// Grant legality and fairness are checked in the stimulus process.
module tb_sm3_adder_arb;

   localparam int N  = 4;
   localparam int IW = 2;

   logic            clk = 1'b0;
   logic            rst;
   logic [N-1:0]    req_valid;
   logic [N-1:0]    req_ready;
   logic [N*32-1:0] req_a, req_b, req_c;
   logic            rsp_valid;
   logic            rsp_ready;
   logic [IW-1:0]   rsp_id;
   logic [31:0]     rsp_sum;

   logic [31:0] op_a [N];
   logic [31:0] op_b [N];
   logic [31:0] op_c [N];
   logic [31:0] exp_sum [N];

   typedef struct packed {
      logic [IW-1:0] id;
      logic [31:0]   sum;
   } rsp_t;

   rsp_t sb_q[$];
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < N; g++) begin : g_pack
      assign req_a[g*32 +: 32] = op_a[g];
      assign req_b[g*32 +: 32] = op_b[g];
      assign req_c[g*32 +: 32] = op_c[g];
   end

   sm3_adder_arb #(.NUM_REQ(N), .ID_W(IW)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a     (req_a),
      .req_b     (req_b),
      .req_c     (req_c),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_id    (rsp_id),
      .rsp_sum   (rsp_sum)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   // Monitor: every consumed response must match the oldest expected one.
   always @(negedge clk) begin
      rsp_t e;
      if (!rst && rsp_valid && rsp_ready) begin
         if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_rsp actual id=%0d sum=%h expected none", rsp_id, rsp_sum);
         end else begin
            e = sb_q.pop_front();
            chk("rsp_id", 32'(rsp_id), 32'(e.id));
            chk("rsp_sum", rsp_sum, e.sum);
         end
      end
   end

   // Record every accepted request as an expected response.
   task automatic push_accepts();
      rsp_t e;
      for (int i = 0; i < N; i++) begin
         if (req_valid[i] && req_ready[i]) begin
            e.id  = IW'(i);
            e.sum = exp_sum[i];
            sb_q.push_back(e);
         end
      end
   endtask

   // One clock: drive at posedge+1, check req_ready at negedge.
   task automatic cyc(input logic [N-1:0] v, input logic rdy, input logic [N-1:0] exp_rdy,
                      input string name);
      req_valid = v;
      rsp_ready = rdy;
      @(negedge clk);
      chk(name, 32'(req_ready), 32'(exp_rdy));
      push_accepts();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input int n);
      rst       = 1'b1;
      req_valid = '1;
      rsp_ready = 1'b0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         chk("ready_in_reset", 32'(req_ready), 32'h0);
         @(posedge clk);
         #1;
      end
      rst       = 1'b0;
      req_valid = '0;
      sb_q.delete();
      chk("reset_rsp_valid", 32'(rsp_valid), 32'h0);
      chk("reset_rsp_id", 32'(rsp_id), 32'h0);
      chk("reset_rsp_sum", rsp_sum, 32'h0);
   endtask

   initial begin
      int          wait_cnt [N];
      logic        can_acc;
      logic [N-1:0] acc;

      rst       = 1'b1;
      req_valid = '0;
      rsp_ready = 1'b0;
      op_a[0] = 32'h00000001; op_b[0] = 32'h00000002; op_c[0] = 32'h00000003; exp_sum[0] = 32'h00000006;
      op_a[1] = 32'hFFFFFFFF; op_b[1] = 32'h00000001; op_c[1] = 32'h00000001; exp_sum[1] = 32'h00000001;
      op_a[2] = 32'hFFFFFFFF; op_b[2] = 32'h80000000; op_c[2] = 32'h80000001; exp_sum[2] = 32'h00000000;
      op_a[3] = 32'h12345678; op_b[3] = 32'h11111111; op_c[3] = 32'h01010101; exp_sum[3] = 32'h2446688A;

      do_reset(2);

      // First handshake right after reset, then a plain drain.
      cyc(4'b0001, 1'b1, 4'b0001, "first_grant");
      cyc(4'b0000, 1'b1, 4'b0000, "idle_drain");
      chk("drain_valid_low", 32'(rsp_valid), 32'h0);
      chk("drain_sum_hold", rsp_sum, 32'h00000006);
      chk("drain_id_hold", 32'(rsp_id), 32'h0);

      // All four requesting: strict rotation, one result per clock.
      do_reset(1);
      for (int k = 0; k < 8; k++) begin
         cyc(4'b1111, 1'b1, 4'b0001 << (k % 4), "rr_rotation");
      end
      cyc(4'b0000, 1'b1, 4'b0000, "rr_drain");

      // Stalled response blocks grants and stays stable; release drains and reloads.
      cyc(4'b0001, 1'b1, 4'b0001, "stall_load");
      for (int k = 0; k < 3; k++) begin
         cyc(4'b0010, 1'b0, 4'b0000, "stall_ready");
         chk("stall_valid", 32'(rsp_valid), 32'h1);
         chk("stall_id", 32'(rsp_id), 32'h0);
         chk("stall_sum", rsp_sum, 32'h00000006);
      end
      cyc(4'b0010, 1'b1, 4'b0010, "stall_release");
      chk("back_to_back_valid", 32'(rsp_valid), 32'h1);
      cyc(4'b0000, 1'b1, 4'b0000, "stall_drain");

      // Reset while a result is pending discards it and restores priority to 0.
      cyc(4'b0100, 1'b1, 4'b0100, "pend_load");
      chk("pend_valid", 32'(rsp_valid), 32'h1);
      do_reset(1);
      cyc(4'b1001, 1'b1, 4'b0001, "rst_prio0");
      cyc(4'b1000, 1'b1, 4'b1000, "rst_prio3");
      cyc(4'b0000, 1'b1, 4'b0000, "rst_drain");

      // Random traffic; requesters hold valid until accepted.
      for (int i = 0; i < N; i++) wait_cnt[i] = 0;
      req_valid = '0;
      for (int n = 0; n < 3000; n++) begin
         for (int i = 0; i < N; i++) begin
            if (!req_valid[i] && ($urandom_range(0, 1) == 1)) begin
               op_a[i]    = $urandom;
               op_b[i]    = $urandom;
               op_c[i]    = $urandom;
               exp_sum[i] = op_a[i] + op_b[i] + op_c[i];
               req_valid[i] = 1'b1;
               wait_cnt[i]  = 0;
            end
         end
         rsp_ready = ($urandom_range(0, 3) != 0);
         can_acc   = !rsp_valid || rsp_ready;
         @(negedge clk);
         chk("rand_ready_legal",
             32'(((req_ready & ~req_valid) == '0) && $onehot0(req_ready) && (can_acc || req_ready == '0)),
             32'h1);
         chk("rand_ready_live", 32'(req_ready != '0), 32'((req_valid != '0) && can_acc));
         push_accepts();
         acc = req_valid & req_ready;
         if (acc != '0) begin
            for (int j = 0; j < N; j++) begin
               if (req_valid[j] && !acc[j]) begin
                  wait_cnt[j]++;
                  chk("rand_starve", 32'(wait_cnt[j] <= 3), 32'h1);
               end
            end
         end
         @(posedge clk);
         #1;
         req_valid = req_valid & ~acc;
      end
      req_valid = '0;
      rsp_ready = 1'b1;
      repeat (3) begin
         @(posedge clk);
         #1;
      end
      chk("sb_empty", 32'(sb_q.size()), 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
